// File: rtl/spi_slave_mode_pkg.sv
// Shared types and helpers for the SPI slave: FSM state encoding and
// the CPOL/CPHA to sample-edge mapping.
package spi_slave_mode_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
  function automatic bit sample_on_rise(input int cpol, input int cpha);
    return (cpol != 0) == (cpha != 0);
  endfunction

endpackage

// File: rtl/spi_slave_mode_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with rise/fall pulses
// on the synchronised level. Resets to the pin's idle level so no edge is seen at reset.
module spi_sync_edge
  import spi_slave_mode_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit IDLE_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{IDLE_VAL}};
      prev <= IDLE_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_mode.sv
// SPI slave for all four CPOL/CPHA modes with a one-word TX holding register,
// RX word strobe, underrun and truncated-frame reporting, all in the clk domain.
module spi_slave_mode
  import spi_slave_mode_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam bit                SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam int                CNT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_W - 1);

  spi_state_e              state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_W-1:0]       hold_data;
  logic [DATA_W-1:0]       tx_shift;
  logic [DATA_W-1:0]       rx_shift;
  logic [SYNC_STAGES-1:0]  mosi_sync;

  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_q;

  logic              ss_active, sclk_edge, sample_edge, shift_edge, last_bit;
  logic              do_load, capture;
  logic [DATA_W-1:0] load_word, load_shift, rx_next;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE_VAL   (CPOL != 0)
  ) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE_VAL   (1'b1)
  ) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ss_n),
    .q    (ss_q),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // mosi goes through the same depth as sclk so the sampled bit lines up with the edge.
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  always_comb begin
    ss_active   = ~ss_q;
    sclk_edge   = ss_active & (sclk_rise | sclk_fall);
    sample_edge = sclk_edge & (sclk_q == SAMPLE_RISE);
    shift_edge  = sclk_edge & (sclk_q != SAMPLE_RISE);
    last_bit    = (bit_cnt == LAST_BIT);
    do_load     = !ss_rise && ((state == LOAD) ||
                               ((state == SHIFT) && sample_edge && last_bit));
    load_word   = tx_ready ? '0 : hold_data;
    load_shift  = (CPHA == 0) ? shift_out(load_word) : load_word;
    capture     = tx_valid & tx_ready;
    rx_next     = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], mosi_q}
                                   : {mosi_q, rx_shift[DATA_W-1:1]};
  end

  // TX handshake: a word moves into the holding register on any cycle where
  // tx_valid && tx_ready; tx_ready is 1 exactly when the holding register is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      hold_data   <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      mosi_sync   <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;

      // A load in the same cycle as a capture takes the old contents; the new word stays held.
      if (capture) begin
        hold_data <= tx_data;
        tx_ready  <= 1'b0;
      end else if (do_load) begin
        tx_ready  <= 1'b1;
      end
      if (do_load) begin
        tx_underrun <= tx_ready;
      end

      if (ss_rise) begin
        state     <= IDLE;
        busy      <= 1'b0;
        miso_oe   <= 1'b0;
        miso      <= 1'b0;
        bit_cnt   <= '0;
        rx_shift  <= '0;
        frame_err <= (state == SHIFT) && (bit_cnt != '0);
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              state   <= LOAD;
              busy    <= 1'b1;
              miso_oe <= 1'b1;
            end
          end
          LOAD: begin
            state    <= SHIFT;
            tx_shift <= load_shift;
            if (CPHA == 0) begin
              miso <= first_bit(load_word);
            end
          end
          SHIFT: begin
            if (sample_edge) begin
              if (last_bit) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= load_shift;
                if (CPHA == 0) begin
                  miso <= first_bit(load_word);
                end
              end else begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end else if (shift_edge && !((CPHA == 0) && (bit_cnt == '0))) begin
              // In CPHA=0 the trailing edge after the last bit is skipped: bit 0 is already out.
              miso     <= first_bit(tx_shift);
              tx_shift <= shift_out(tx_shift);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed bench: four 16-bit LSB-first instances (one per SPI mode) and one
// 8-bit MSB-first mode-0 instance, driven by a bit-banged SPI master task.
module tb_spi_slave_mode;

  localparam int HALF = 5;
  localparam int SYNC = 2;
  localparam int D8   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  sclk_v = 5'b01100;
  logic [4:0]  ss_v = 5'b11111;
  logic [4:0]  mosi_v = 5'b00000;
  logic [4:0]  tx_valid_v = 5'b00000;
  logic [15:0] tx_word = 16'h0;

  logic [4:0]  miso_v, miso_oe_v, tx_ready_v, rx_valid_v, udr_v, ferr_v, busy_v;
  logic [15:0] rx16 [4];
  logic [7:0]  rx8;

  int  n_cmp = 0;
  int  n_fail = 0;
  int  rxv_cnt [5];
  int  udr_cnt [5];
  int  ferr_cnt [5];
  int  lat [5];
  time t_samp [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_mode #(
      .DATA_W(16), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(0), .SYNC_STAGES(SYNC)
    ) u_dut16 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_v[g]), .mosi(mosi_v[g]), .ss_n(ss_v[g]),
      .miso(miso_v[g]), .miso_oe(miso_oe_v[g]), .tx_data(tx_word), .tx_valid(tx_valid_v[g]),
      .tx_ready(tx_ready_v[g]), .rx_data(rx16[g]), .rx_valid(rx_valid_v[g]),
      .tx_underrun(udr_v[g]), .frame_err(ferr_v[g]), .busy(busy_v[g])
    );
  end

  spi_slave_mode #(
    .DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(SYNC)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_v[D8]), .mosi(mosi_v[D8]), .ss_n(ss_v[D8]),
    .miso(miso_v[D8]), .miso_oe(miso_oe_v[D8]), .tx_data(tx_word[7:0]), .tx_valid(tx_valid_v[D8]),
    .tx_ready(tx_ready_v[D8]), .rx_data(rx8), .rx_valid(rx_valid_v[D8]),
    .tx_underrun(udr_v[D8]), .frame_err(ferr_v[D8]), .busy(busy_v[D8])
  );

  // Pulse monitor: counts strobes and measures rx_valid latency from the last sample edge.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rx_valid_v[i]) begin
        rxv_cnt[i] = rxv_cnt[i] + 1;
        lat[i] = int'(($time - t_samp[i]) / 10);
      end
      if (udr_v[i])  udr_cnt[i]  = udr_cnt[i] + 1;
      if (ferr_v[i]) ferr_cnt[i] = ferr_cnt[i] + 1;
    end
  end

  function automatic logic [15:0] rx_of(input int idx);
    return (idx == D8) ? {8'h00, rx8} : rx16[idx];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tx_push(input int idx, input logic [15:0] w);
    int n;
    n = 0;
    tx_word = w;
    tx_valid_v[idx] = 1'b1;
    while (!tx_ready_v[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tx_push_timeout: idx %0d tx_ready never rose", idx);
    end
    @(negedge clk);
    tx_valid_v[idx] = 1'b0;
  endtask

  task automatic spi_select(input int idx);
    ss_v[idx] = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_deselect(input int idx);
    ss_v[idx] = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Shifts nbits of a width-bit word; master samples miso on the sample edge.
  task automatic spi_word(input int idx, input int width, input int nbits,
                          input logic [15:0] mo, output logic [15:0] mi);
    bit cpol, cpha, msb;
    int pos;
    cpol = (idx == D8) ? 1'b0 : idx[1];
    cpha = (idx == D8) ? 1'b0 : idx[0];
    msb  = (idx == D8);
    mi = 16'h0;
    for (int i = 0; i < nbits; i++) begin
      pos = msb ? (width - 1 - i) : i;
      if (!cpha) begin
        mosi_v[idx] = mo[pos];
        repeat (HALF) @(negedge clk);
        mi[pos] = miso_v[idx];
        sclk_v[idx] = ~cpol;
        t_samp[idx] = $time;
        repeat (HALF) @(negedge clk);
        sclk_v[idx] = cpol;
      end else begin
        sclk_v[idx] = ~cpol;
        mosi_v[idx] = mo[pos];
        repeat (HALF) @(negedge clk);
        mi[pos] = miso_v[idx];
        sclk_v[idx] = cpol;
        t_samp[idx] = $time;
        repeat (HALF) @(negedge clk);
      end
    end
    if (!cpha) repeat (HALF) @(negedge clk);
  endtask

  typedef struct {
    int          idx;
    logic [15:0] mo;
    logic [15:0] tx;
    logic [15:0] exp_rx;
    logic [15:0] exp_mi;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [15:0] mi;
    int rxv0, udr0, ferr0, w, idx;

    vecs[0] = '{D8, 16'h00A5, 16'h003C, 16'h00A5, 16'h003C};
    vecs[1] = '{0,  16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
    vecs[2] = '{1,  16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
    vecs[3] = '{2,  16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
    vecs[4] = '{3,  16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
    vecs[5] = '{D8, 16'h0001, 16'h0080, 16'h0001, 16'h0080};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_miso",     {27'h0, miso_v},     32'h0);
    check("rst_miso_oe",  {27'h0, miso_oe_v},  32'h0);
    check("rst_tx_ready", {27'h0, tx_ready_v}, 32'h1f);
    check("rst_rx_valid", {27'h0, rx_valid_v}, 32'h0);
    check("rst_underrun", {27'h0, udr_v},      32'h0);
    check("rst_frame_err",{27'h0, ferr_v},     32'h0);
    check("rst_busy",     {27'h0, busy_v},     32'h0);
    check("rst_rx8",      {24'h0, rx8},        32'h0);
    check("rst_rx16",     {16'h0, rx16[2]},    32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single-word transfers across modes and bit orders
    for (int v = 0; v < 6; v++) begin
      idx = vecs[v].idx;
      w = (idx == D8) ? 8 : 16;
      rxv0 = rxv_cnt[idx]; udr0 = udr_cnt[idx]; ferr0 = ferr_cnt[idx];
      tx_push(idx, vecs[v].tx);
      check($sformatf("v%0d_tx_ready_full", v), tx_ready_v[idx], 1'b0);
      spi_select(idx);
      check($sformatf("v%0d_busy", v), busy_v[idx], 1'b1);
      check($sformatf("v%0d_miso_oe", v), miso_oe_v[idx], 1'b1);
      check($sformatf("v%0d_load_no_udr", v), udr_cnt[idx] - udr0, 0);
      spi_word(idx, w, w, vecs[v].mo, mi);
      spi_deselect(idx);
      check($sformatf("v%0d_rx_data", v), rx_of(idx), vecs[v].exp_rx);
      check($sformatf("v%0d_master_rd", v), mi, vecs[v].exp_mi);
      check($sformatf("v%0d_rx_valid_cnt", v), rxv_cnt[idx] - rxv0, 1);
      check($sformatf("v%0d_latency", v), lat[idx], SYNC + 1);
      check($sformatf("v%0d_frame_err", v), ferr_cnt[idx] - ferr0, 0);
      check($sformatf("v%0d_reload_udr", v), udr_cnt[idx] - udr0, 1);
      check($sformatf("v%0d_idle_busy", v), busy_v[idx], 1'b0);
      check($sformatf("v%0d_idle_oe", v), miso_oe_v[idx], 1'b0);
      check($sformatf("v%0d_idle_miso", v), miso_v[idx], 1'b0);
    end

    // Back-to-back words with ss_n held low
    rxv0 = rxv_cnt[D8]; udr0 = udr_cnt[D8];
    tx_push(D8, 16'h11);
    spi_select(D8);
    tx_push(D8, 16'h22);
    spi_word(D8, 8, 8, 16'h96, mi);
    check("b2b_rd1", mi, 16'h11);
    check("b2b_rx1", rx8, 8'h96);
    tx_push(D8, 16'h33);
    spi_word(D8, 8, 8, 16'h69, mi);
    check("b2b_rd2", mi, 16'h22);
    check("b2b_rx2", rx8, 8'h69);
    spi_deselect(D8);
    check("b2b_rx_valid_cnt", rxv_cnt[D8] - rxv0, 2);
    check("b2b_no_underrun", udr_cnt[D8] - udr0, 0);

    // Select with an empty holding register
    udr0 = udr_cnt[D8];
    spi_select(D8);
    check("udr_at_load", udr_cnt[D8] - udr0, 1);
    tx_push(D8, 16'h77);
    spi_word(D8, 8, 8, 16'h0F, mi);
    spi_deselect(D8);
    check("udr_master_rd", mi, 16'h00);
    check("udr_rx", rx8, 8'h0F);
    check("udr_single_pulse", udr_cnt[D8] - udr0, 1);

    // Truncated frame after 5 bits; holding register must survive
    rxv0 = rxv_cnt[D8]; udr0 = udr_cnt[D8]; ferr0 = ferr_cnt[D8];
    tx_push(D8, 16'hC6);
    spi_select(D8);
    tx_push(D8, 16'h3E);
    spi_word(D8, 8, 5, 16'hFF, mi);
    spi_deselect(D8);
    check("ferr_pulse", ferr_cnt[D8] - ferr0, 1);
    check("ferr_no_rx_valid", rxv_cnt[D8] - rxv0, 0);
    check("ferr_rx_kept", rx8, 8'h0F);
    check("ferr_partial_rd", mi, 16'hC0);
    check("ferr_hold_kept", tx_ready_v[D8], 1'b0);
    check("ferr_no_udr", udr_cnt[D8] - udr0, 0);
    spi_select(D8);
    spi_word(D8, 8, 8, 16'h5A, mi);
    spi_deselect(D8);
    check("ferr_next_rx", rx8, 8'h5A);
    check("ferr_next_rd", mi, 16'h3E);
    check("ferr_next_rxv", rxv_cnt[D8] - rxv0, 1);
    check("ferr_clean_end", ferr_cnt[D8] - ferr0, 1);

    // Asynchronous reset in the middle of a word
    tx_push(D8, 16'hE7);
    spi_select(D8);
    spi_word(D8, 8, 4, 16'h33, mi);
    rst_n = 1'b0;
    #1;
    check("arst_miso", miso_v[D8], 1'b0);
    check("arst_miso_oe", miso_oe_v[D8], 1'b0);
    check("arst_tx_ready", tx_ready_v[D8], 1'b1);
    check("arst_rx_data", rx8, 8'h00);
    check("arst_busy", busy_v[D8], 1'b0);
    check("arst_pulses", {rx_valid_v[D8], udr_v[D8], ferr_v[D8]}, 3'b000);
    ss_v[D8] = 1'b1;
    sclk_v[D8] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rxv0 = rxv_cnt[D8]; ferr0 = ferr_cnt[D8];
    tx_push(D8, 16'h24);
    spi_select(D8);
    spi_word(D8, 8, 8, 16'hC3, mi);
    spi_deselect(D8);
    check("arst_next_rx", rx8, 8'hC3);
    check("arst_next_rd", mi, 16'h24);
    check("arst_next_rxv", rxv_cnt[D8] - rxv0, 1);
    check("arst_no_ferr", ferr_cnt[D8] - ferr0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
